// File: rtl/csv_vector_emitter.sv
// Serialises timestamped signal samples into ASCII CSV lines on a byte stream.
// Optional macro CSV_HEADER_EN emits a column header line after every reset.
module csv_vector_emitter #(
  parameter int NUM_SIGS  = 4,
  parameter int TS_WIDTH  = 32,
  parameter int TS_DIGITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [TS_WIDTH-1:0] sample_ts,
  input  logic [NUM_SIGS-1:0] sample_bits,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                busy
);

  localparam int BW = 4 * TS_DIGITS;
  localparam int CW = $clog2(TS_WIDTH + 1);
  localparam int DW = $clog2(TS_DIGITS + 1);
  localparam int IW = $clog2(NUM_SIGS + 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(TS_WIDTH - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(NUM_SIGS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONV   = 3'd1,
    S_DIGITS = 3'd2,
    S_SEP    = 3'd3,
    S_BIT    = 3'd4,
    S_EOL    = 3'd5,
    S_HDR    = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [NUM_SIGS-1:0] bits_q, bits_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [IW-1:0]       bidx_q, bidx_d;

  logic                xfer;
  logic [BW-1:0]       bcd_sh;
  logic [NUM_SIGS-1:0] bits_sh;

`ifdef CSV_HEADER_EN
  localparam int HDR_LEN = 10 + 3 * NUM_SIGS;
  localparam int HW = $clog2(HDR_LEN);
  localparam logic [HW-1:0] HDR_LAST = HW'(HDR_LEN - 1);
  localparam state_e RST_STATE = S_HDR;

  logic [HW-1:0] hidx_q, hidx_d;

  // "timestamp", then ",s<i>" per signal, then LF
  function automatic logic [7:0] hdr_char(input logic [HW-1:0] idx);
    int k;
    int j;
    k = int'(idx);
    j = k - 9;
    hdr_char = 8'h0a;
    if (k < 9) begin
      case (k)
        0:       hdr_char = 8'h74;
        1:       hdr_char = 8'h69;
        2:       hdr_char = 8'h6d;
        3:       hdr_char = 8'h65;
        4:       hdr_char = 8'h73;
        5:       hdr_char = 8'h74;
        6:       hdr_char = 8'h61;
        7:       hdr_char = 8'h6d;
        default: hdr_char = 8'h70;
      endcase
    end else if (j < 3 * NUM_SIGS) begin
      case (j % 3)
        0:       hdr_char = 8'h2c;
        1:       hdr_char = 8'h73;
        default: hdr_char = 8'h30 + 8'(j / 3);
      endcase
    end
  endfunction
`else
  localparam state_e RST_STATE = S_IDLE;
`endif

  // One shift-and-add-3 step: correct digits >= 5, then shift in next bit
  function automatic logic [BW-1:0] bcd_step(
    input logic [BW-1:0] b,
    input logic          sin
  );
    logic [BW-1:0] a;
    a = b;
    for (int i = 0; i < TS_DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd4) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    bcd_step = {a[BW-2:0], sin};
  endfunction

  function automatic logic [DW-1:0] sig_digits(input logic [BW-1:0] b);
    sig_digits = DW'(1);
    for (int i = 1; i < TS_DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) sig_digits = DW'(i + 1);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      ts_q    <= '0;
      bits_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      bidx_q  <= '0;
`ifdef CSV_HEADER_EN
      hidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      bits_q  <= bits_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      bidx_q  <= bidx_d;
`ifdef CSV_HEADER_EN
      hidx_q  <= hidx_d;
`endif
    end
  end

  assign xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    bits_d  = bits_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    bidx_d  = bidx_q;
`ifdef CSV_HEADER_EN
    hidx_d  = hidx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          ts_d    = sample_ts;
          bits_d  = sample_bits;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = bcd_step(bcd_q, ts_q[TS_WIDTH-1]);
        ts_d  = ts_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CONV_LAST) begin
          dcnt_d  = sig_digits(bcd_d);
          state_d = S_DIGITS;
        end
      end
      S_DIGITS: begin
        if (xfer) begin
          if (dcnt_q == DW'(1)) begin
            bidx_d  = '0;
            state_d = S_SEP;
          end else begin
            dcnt_d = dcnt_q - 1'b1;
          end
        end
      end
      S_SEP: begin
        if (xfer) state_d = S_BIT;
      end
      S_BIT: begin
        if (xfer) begin
          if (bidx_q == BIT_LAST) begin
            state_d = S_EOL;
          end else begin
            bidx_d  = bidx_q + 1'b1;
            state_d = S_SEP;
          end
        end
      end
      S_EOL: begin
        if (xfer) state_d = S_IDLE;
      end
`ifdef CSV_HEADER_EN
      S_HDR: begin
        if (xfer) begin
          if (hidx_q == HDR_LAST) state_d = S_IDLE;
          else hidx_d = hidx_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bcd_sh       = bcd_q >> (4 * (dcnt_q - 1'b1));
    bits_sh      = bits_q >> bidx_q;
    sample_ready = 1'b0;
    busy         = 1'b1;
    out_valid    = 1'b0;
    out_data     = 8'h00;
    case (state_q)
      S_IDLE: begin
        sample_ready = 1'b1;
        busy         = 1'b0;
      end
      S_DIGITS: begin
        out_valid = 1'b1;
        out_data  = {4'h3, bcd_sh[3:0]};
      end
      S_SEP: begin
        out_valid = 1'b1;
        out_data  = 8'h2c;
      end
      S_BIT: begin
        out_valid = 1'b1;
        out_data  = {7'h18, bits_sh[0]};
      end
      S_EOL: begin
        out_valid = 1'b1;
        out_data  = 8'h0a;
      end
`ifdef CSV_HEADER_EN
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_char(hidx_q);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csv_vector_emitter.sv
// Directed bench for csv_vector_emitter (default build, no header).
// Expected lines are hand-written ASCII strings.
module tb_csv_vector_emitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] sample_ts;
  logic [3:0]  sample_bits;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_cyc = 0;
  int lf_cyc = 0;

  logic [7:0] rx[$];
  logic       ov_prev = 1'b0;
  logic       stall_prev = 1'b0;
  logic       rst_prev = 1'b1;
  logic [7:0] d_prev = 8'h00;

  csv_vector_emitter #(
    .NUM_SIGS (4),
    .TS_WIDTH (32),
    .TS_DIGITS(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_ts   (sample_ts),
    .sample_bits (sample_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte collector and handshake checks, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rdy_busy", sample_ready, !busy);
      if (stall_prev && !rst_prev) begin
        chk("hold_v", out_valid, 1'b1);
        chk("hold_d", out_data, d_prev);
      end
      if (sample_valid && sample_ready) begin
        n_acc++;
        acc_cyc = cyc;
      end
      if (out_valid && !ov_prev) first_cyc = cyc;
      if (out_valid && out_ready) begin
        rx.push_back(out_data);
        if (out_data == 8'h0a) lf_cyc = cyc;
      end
    end
    ov_prev    = out_valid;
    stall_prev = out_valid && !out_ready;
    d_prev     = out_data;
    rst_prev   = rst;
  end

  task automatic send(input logic [31:0] ts, input logic [3:0] b);
    int base;
    base = n_acc;
    sample_valid = 1'b1;
    sample_ts    = ts;
    sample_bits  = b;
    for (int t = 0; t < 400 && n_acc == base; t++) begin
      @(posedge clk);
      #1;
    end
    chk("accept", n_acc, base + 1);
    sample_valid = 1'b0;
    sample_ts    = ~ts;
    sample_bits  = ~b;
  endtask

  task automatic expect_line(input string tag, input string s, input bit rbp);
    logic [7:0] got;
    for (int t = 0; t < 2000 && rx.size() < s.len(); t++) begin
      @(posedge clk);
      #1;
      if (rbp) out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    chk({tag, "_len"}, rx.size(), s.len());
    for (int i = 0; i < s.len(); i++) begin
      got = (i < rx.size()) ? rx[i] : 8'hff;
      chk($sformatf("%s[%0d]", tag, i), got, s[i]);
    end
    rx.delete();
  endtask

  initial begin
    int base;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_ts    = '0;
    sample_bits  = '0;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_od", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", sample_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(32'd0, 4'b0101);
    expect_line("min", "0,1,0,1,0\n", 1'b0);
    // first byte 33 cycles after the accept cycle; LF at 32 + 10 bytes
    chk("latency", first_cyc - acc_cyc, 33);
    chk("line_cyc", lf_cyc - acc_cyc, 42);

    send(32'hffff_ffff, 4'b1111);
    expect_line("max", "4294967295,1,1,1,1\n", 1'b0);

    send(32'd1000000, 4'b0110);
    expect_line("zeros", "1000000,0,1,1,0\n", 1'b0);

    base = n_acc;
    sample_valid = 1'b1;
    sample_ts    = 32'd7;
    sample_bits  = 4'b0000;
    for (int t = 0; t < 400 && n_acc == base; t++) begin
      @(posedge clk);
      #1;
    end
    sample_ts   = 32'd10;
    sample_bits = 4'b1000;
    for (int t = 0; t < 400 && n_acc == base + 1; t++) begin
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    chk("b2b_acc", n_acc, base + 2);
    chk("b2b_gap", acc_cyc - lf_cyc, 1);
    expect_line("b2b", "7,0,0,0,0\n10,0,0,0,1\n", 1'b0);

    send(32'd1234, 4'b0011);
    expect_line("bp", "1234,1,1,0,0\n", 1'b1);

    send(32'd555, 4'b0000);
    for (int t = 0; t < 400 && rx.size() < 3; t++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_rdy", sample_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    expect_line("part", "555", 1'b0);

    send(32'd1, 4'b0001);
    expect_line("after", "1,1,0,0,0\n", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
